// File: rtl/mem_responder_if.sv
// Memory-port bundle between a MEM-stage initiator and the data-memory responder.
// The shared data bus is resolved here from the two agents' drive/enable pairs.
interface mem_responder_if #(
    parameter int WORD_SIZE = 16
);
    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;
    logic [WORD_SIZE-1:0] init_data;
    logic                 init_oe;

    logic                 ready;
    logic                 err;
    logic [15:0]          read_count;
    logic [15:0]          write_count;
    logic [WORD_SIZE-1:0] rsp_data;
    logic                 rsp_oe;

    wire  [WORD_SIZE-1:0] data;

    // Responder wins while returning read data; otherwise the initiator may drive.
    assign data = rsp_oe ? rsp_data : (init_oe ? init_data : {WORD_SIZE{1'bz}});

    modport master (
        output readM, writeM, address, init_data, init_oe,
        input  ready, err, read_count, write_count, data, rsp_oe
    );

    modport slave (
        input  readM, writeM, address, data,
        output ready, err, read_count, write_count, rsp_data, rsp_oe
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed data-memory responder with fixed access latency, one-cycle
// ready/err pulses, tristated read data and saturating access counters.
module mem_responder #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   op_write_q;
    logic [ADDR_BITS-1:0]   index_q;
    logic [3:0]             cnt_q;
    logic                   ready_q;
    logic                   err_q;
    logic [15:0]            read_count_q;
    logic [15:0]            write_count_q;
    logic [WORD_SIZE-1:0]   rdata_q;
    logic [WORD_SIZE-1:0]   mem [DEPTH];

    logic [ADDR_BITS-1:0]   req_index;
    logic [ADDR_BITS-1:0]   rd_index;
    logic                   req_active;
    logic                   commit_write;

    assign req_index    = bus.address[ADDR_BITS-1:0];
    assign req_active   = op_write_q ? bus.writeM : bus.readM;
    assign commit_write = !reset && (state_q == RESP) && op_write_q;

    generate
        if (ADDR_BITS < WORD_SIZE) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.address[WORD_SIZE-1:ADDR_BITS];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            op_write_q    <= 1'b0;
            index_q       <= '0;
            cnt_q         <= '0;
            ready_q       <= 1'b0;
            err_q         <= 1'b0;
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.readM ^ bus.writeM) begin
                        op_write_q <= bus.writeM;
                        index_q    <= req_index;
                        cnt_q      <= LOAD_CNT;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end else if (bus.readM && bus.writeM) begin
                        err_q <= 1'b1;
                    end
                end
                BUSY: begin
                    // A dropped request abandons the access with no side effects.
                    if (!req_active) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    if (op_write_q) begin
                        if (write_count_q != 16'hFFFF) write_count_q <= write_count_q + 16'd1;
                    end else begin
                        if (read_count_q != 16'hFFFF) read_count_q <= read_count_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Registered read port: the word is fetched on the edge entering RESP.
    assign rd_index = (state_q == IDLE) ? req_index : index_q;

    always_ff @(posedge clk) begin
        if (commit_write) begin
            mem[index_q] <= bus.data;
        end
        rdata_q <= mem[rd_index];
    end

    assign bus.ready       = ready_q;
    assign bus.err         = err_q;
    assign bus.read_count  = read_count_q;
    assign bus.write_count = write_count_q;
    assign bus.rsp_data    = rdata_q;
    assign bus.rsp_oe      = (state_q == RESP) && !op_write_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (latency 1, 2, 3) checked against a
// transaction-level model of memory contents and access counters.
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if #(.WORD_SIZE(16)) b1 ();
    mem_responder_if #(.WORD_SIZE(16)) b2 ();
    mem_responder_if #(.WORD_SIZE(16)) b3 ();

    mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
    mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(2)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));
    mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(3)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));

    int checks = 0;
    int errors = 0;

    // Reference model, indexed by instance (0 -> latency 1, 1 -> 2, 2 -> 3).
    logic [15:0] mdl_mem   [3][256];
    bit          mdl_valid [3][256];
    int unsigned mdl_rc    [3];
    int unsigned mdl_wc    [3];

    task automatic drive(input int sel, input bit rd, input bit wr, input logic [15:0] a,
                         input logic [15:0] d, input bit oe);
        case (sel)
            0: begin b1.readM = rd; b1.writeM = wr; b1.address = a; b1.init_data = d; b1.init_oe = oe; end
            1: begin b2.readM = rd; b2.writeM = wr; b2.address = a; b2.init_data = d; b2.init_oe = oe; end
            default: begin b3.readM = rd; b3.writeM = wr; b3.address = a; b3.init_data = d; b3.init_oe = oe; end
        endcase
    endtask

    task automatic sample(input int sel, output logic rdy, output logic e, output logic oe,
                          output logic [15:0] dat, output logic [15:0] rc, output logic [15:0] wc);
        case (sel)
            0: begin rdy = b1.ready; e = b1.err; oe = b1.rsp_oe; dat = b1.data; rc = b1.read_count; wc = b1.write_count; end
            1: begin rdy = b2.ready; e = b2.err; oe = b2.rsp_oe; dat = b2.data; rc = b2.read_count; wc = b2.write_count; end
            default: begin rdy = b3.ready; e = b3.err; oe = b3.rsp_oe; dat = b3.data; rc = b3.read_count; wc = b3.write_count; end
        endcase
    endtask

    task automatic check_idle(input int sel, input string tag);
        logic rdy, e, oe;
        logic [15:0] dat, rc, wc;
        sample(sel, rdy, e, oe, dat, rc, wc);
        checks++;
        if ({rdy, oe, e} !== 3'b000) begin
            errors++;
            $display("FAIL %s L=%0d idle flags {ready,drive,err}=%b expected 000", tag, sel + 1, {rdy, oe, e});
        end
        checks++;
        if (rc !== 16'(mdl_rc[sel]) || wc !== 16'(mdl_wc[sel])) begin
            errors++;
            $display("FAIL %s L=%0d counters rd=%0d wr=%0d expected rd=%0d wr=%0d",
                     tag, sel + 1, rc, wc, mdl_rc[sel], mdl_wc[sel]);
        end
    endtask

    // One access; abort_cyc>0 drops the request at the start of that cycle.
    task automatic access(input int sel, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wd, input int abort_cyc, input string tag);
        int lat;
        int idx;
        logic rdy, e, oe;
        logic [15:0] dat, rc, wc;
        logic [2:0] exp_flags;
        logic [15:0] got_data;
        lat = sel + 1;
        idx = int'(addr[7:0]);
        got_data = 16'h0;
        @(posedge clk); #1;
        drive(sel, !wr, wr, addr, wd, wr);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            if (abort_cyc != 0 && c == abort_cyc) drive(sel, 1'b0, 1'b0, addr, wd, 1'b0);
            else if (abort_cyc == 0) drive(sel, !wr, wr, 16'($urandom), wd, wr);
            @(negedge clk);
            sample(sel, rdy, e, oe, dat, rc, wc);
            exp_flags = {(abort_cyc == 0 && c == lat), (abort_cyc == 0 && c == lat && !wr), 1'b0};
            checks++;
            if ({rdy, oe, e} !== exp_flags) begin
                errors++;
                $display("FAIL %s L=%0d cycle %0d flags {ready,drive,err}=%b expected %b",
                         tag, lat, c, {rdy, oe, e}, exp_flags);
            end
            if (exp_flags[1]) begin
                got_data = dat;
                if (mdl_valid[sel][idx]) begin
                    checks++;
                    if (dat !== mdl_mem[sel][idx]) begin
                        errors++;
                        $display("FAIL %s L=%0d read data addr=%h got %h expected %h",
                                 tag, lat, addr, dat, mdl_mem[sel][idx]);
                    end
                end
            end
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, addr, 16'h0, 1'b0);
        if (abort_cyc == 0) begin
            if (wr) begin
                mdl_mem[sel][idx] = wd;
                mdl_valid[sel][idx] = 1'b1;
                if (mdl_wc[sel] < 32'hFFFF) mdl_wc[sel]++;
            end else begin
                if (mdl_rc[sel] < 32'hFFFF) mdl_rc[sel]++;
            end
        end
        @(negedge clk);
        check_idle(sel, tag);
        $display("txn %s L=%0d %s addr=%h data=%h%s", tag, lat, wr ? "WR" : "RD", addr,
                 wr ? wd : got_data, abort_cyc != 0 ? " aborted" : "");
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) check_idle(s, "reset");
        @(posedge clk); #1;
        reset = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_write_read();
        access(1, 1'b1, 16'h0005, 16'h1234, 0, "write_read");
        access(1, 1'b0, 16'h0005, 16'h0000, 0, "write_read");
    endtask

    task automatic test_wrap();
        access(1, 1'b1, 16'h0103, 16'hBEEF, 0, "wrap");
        access(1, 1'b0, 16'h0003, 16'h0000, 0, "wrap");
    endtask

    task automatic test_abort();
        access(2, 1'b1, 16'h0010, 16'h1111, 0, "abort_setup");
        access(2, 1'b1, 16'h0010, 16'hAAAA, 1, "abort");
        access(2, 1'b0, 16'h0010, 16'h0000, 0, "abort_check");
    endtask

    task automatic test_err();
        logic rdy, e, oe;
        logic [15:0] dat, rc, wc;
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 16'h0005, 16'hDEAD, 1'b1);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 16'h0005, 16'h0, 1'b0);
        @(negedge clk);
        sample(1, rdy, e, oe, dat, rc, wc);
        checks++;
        if ({rdy, oe, e} !== 3'b001) begin
            errors++;
            $display("FAIL err_pulse flags {ready,drive,err}=%b expected 001", {rdy, oe, e});
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_idle(1, "err_after");
        $display("txn err L=2 both requests addr=0005");
        access(1, 1'b0, 16'h0005, 16'h0000, 0, "err_mem");
    endtask

    task automatic test_reset_mid();
        access(2, 1'b1, 16'h0020, 16'h2222, 0, "rstmid_setup");
        @(posedge clk); #1;
        drive(2, 1'b0, 1'b1, 16'h0020, 16'h5555, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            mdl_rc[s] = 0;
            mdl_wc[s] = 0;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        drive(2, 1'b0, 1'b0, 16'h0020, 16'h0, 1'b0);
        @(negedge clk);
        for (int s = 0; s < 3; s++) check_idle(s, "rstmid");
        $display("txn reset during L=3 write addr=0020 data=5555");
        access(2, 1'b0, 16'h0020, 16'h0000, 0, "rstmid_mem");
    endtask

    task automatic test_latency1();
        access(0, 1'b1, 16'h0042, 16'hC0DE, 0, "lat1");
        access(0, 1'b0, 16'h0042, 16'h0000, 0, "lat1");
    endtask

    task automatic test_back_to_back(input int sel);
        int lat;
        logic rdy, e, oe;
        logic [15:0] dat, rc, wc;
        logic exp_rdy;
        lat = sel + 1;
        @(posedge clk); #1;
        drive(sel, 1'b1, 1'b0, 16'h0005, 16'h0, 1'b0);
        for (int c = 1; c <= 2 * lat + 2; c++) begin
            @(posedge clk); #1;
            if (c == 2 * lat + 2) drive(sel, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            @(negedge clk);
            sample(sel, rdy, e, oe, dat, rc, wc);
            exp_rdy = (c == lat) || (c == 2 * lat + 1);
            checks++;
            if ({rdy, oe} !== {exp_rdy, exp_rdy}) begin
                errors++;
                $display("FAIL b2b L=%0d cycle %0d {ready,drive}=%b expected %b",
                         lat, c, {rdy, oe}, {exp_rdy, exp_rdy});
            end
            if (exp_rdy && mdl_valid[sel][5]) begin
                checks++;
                if (dat !== mdl_mem[sel][5]) begin
                    errors++;
                    $display("FAIL b2b L=%0d data got %h expected %h", lat, dat, mdl_mem[sel][5]);
                end
            end
        end
        mdl_rc[sel] += 2;
        @(negedge clk);
        check_idle(sel, "b2b");
        $display("txn back_to_back L=%0d two reads addr=0005", lat);
    endtask

    task automatic test_random();
        int sel;
        bit wr;
        int ab;
        logic [15:0] a;
        logic [15:0] d;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            a = {8'($urandom), 8'(8'h40 + $urandom_range(0, 7))};
            d = 16'($urandom);
            ab = 0;
            if (sel > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, sel);
            access(sel, wr, a, d, ab, "random");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int s = 0; s < 3; s++) begin
            mdl_rc[s] = 0;
            mdl_wc[s] = 0;
            for (int i = 0; i < 256; i++) mdl_valid[s][i] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_wrap();
        test_abort();
        test_err();
        test_reset_mid();
        test_latency1();
        test_back_to_back(1);
        test_back_to_back(2);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
